// File: rtl/tx_sequence_recorder_fifo_pkg.sv
// Shared Tx arbiter definitions: source-ID enum, push/pop mode limits and
// the modular pointer helper used by the sequence recorder FIFO.
package tx_sequence_recorder_fifo_pkg;

   typedef enum logic [2:0] {
      NO_SOURCE     = 3'd0,
      A2P_1         = 3'd1,
      A2P_2         = 3'd2,
      MASTER        = 3'd3,
      RX_ROUTER_CFG = 3'd4,
      RX_ROUTER_ERR = 3'd5
   } tx_source_e;

   localparam int SOURCE_WIDTH = $bits(tx_source_e);
   localparam int WR_MODE_MAX  = 4;
   localparam int RD_MODE_MAX  = 2;

   // One conditional subtract is enough: ptr < depth and n <= 4 <= depth.
   function automatic int unsigned ptr_add(input int unsigned ptr,
                                           input int unsigned n,
                                           input int unsigned depth);
      int unsigned sum;
      sum = ptr + n;
      return (sum >= depth) ? sum - depth : sum;
   endfunction

endpackage

// File: rtl/tx_sequence_recorder_fifo_if.sv
// Arbiter <-> sequence recorder handshake: multi-entry push, 1-2 entry pop,
// show-ahead read data and status back to the arbiter.
interface tx_sequence_recorder_fifo_if #(
   parameter int DATA_WIDTH = 3,
   parameter int FIFO_DEPTH = 10,
   parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH + 1)
);
   logic                  wr_en;
   logic [2:0]            wr_mode;
   logic [DATA_WIDTH-1:0] wr_data_1;
   logic [DATA_WIDTH-1:0] wr_data_2;
   logic [DATA_WIDTH-1:0] wr_data_3;
   logic [DATA_WIDTH-1:0] wr_data_4;
   logic                  rd_en;
   logic [1:0]            rd_mode;
   logic [DATA_WIDTH-1:0] rd_data_1;
   logic [DATA_WIDTH-1:0] rd_data_2;
   logic                  empty;
   logic                  full;
   logic [CNT_WIDTH-1:0]  available;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output wr_en, wr_mode, wr_data_1, wr_data_2, wr_data_3, wr_data_4,
      output rd_en, rd_mode,
      input  rd_data_1, rd_data_2, empty, full, available, overflow, underflow
   );

   modport slave (
      input  wr_en, wr_mode, wr_data_1, wr_data_2, wr_data_3, wr_data_4,
      input  rd_en, rd_mode,
      output rd_data_1, rd_data_2, empty, full, available, overflow, underflow
   );
endinterface

// File: rtl/tx_sequence_recorder_fifo.sv
// Records the order of Tx source requests: up to 4 pushes and 2 show-ahead
// pops per cycle over a register array with modular (non power-of-two) pointers.
module tx_sequence_recorder_fifo
   import tx_sequence_recorder_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 3,
   parameter int FIFO_DEPTH = 10,
   parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
   parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                         clk,
   input  logic                         arst,
   tx_sequence_recorder_fifo_if.slave   bus
);

   typedef logic [DATA_WIDTH-1:0] entry_t;

   localparam entry_t               EMPTY_ENTRY = entry_t'(NO_SOURCE);
   localparam logic [CNT_WIDTH-1:0] DEPTH_CNT   = CNT_WIDTH'(FIFO_DEPTH);

   entry_t                mem_q [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr_q;
   logic [ADDR_WIDTH-1:0] rd_ptr_q;
   logic [CNT_WIDTH-1:0]  count_q;
   logic                  overflow_q;
   logic                  underflow_q;

   entry_t                wr_data [WR_MODE_MAX];
   logic [ADDR_WIDTH-1:0] wr_slot [WR_MODE_MAX];
   logic [ADDR_WIDTH-1:0] wr_ptr_next;
   logic [ADDR_WIDTH-1:0] rd_ptr_next;
   logic [ADDR_WIDTH-1:0] rd_ptr_inc;
   logic [CNT_WIDTH-1:0]  avail;
   logic [CNT_WIDTH-1:0]  wr_num;
   logic [CNT_WIDTH-1:0]  rd_num;
   logic [CNT_WIDTH-1:0]  wr_cnt;
   logic [CNT_WIDTH-1:0]  rd_cnt;
   logic                  wr_mode_ok;
   logic                  rd_mode_ok;
   logic                  wr_accept;
   logic                  wr_drop;
   logic                  rd_short;

   // NOTE: every always_comb target is assigned before any condition, so no latch can be inferred.
   always_comb begin
      wr_data[0] = bus.wr_data_1;
      wr_data[1] = bus.wr_data_2;
      wr_data[2] = bus.wr_data_3;
      wr_data[3] = bus.wr_data_4;

      avail      = DEPTH_CNT - count_q;
      wr_num     = CNT_WIDTH'(bus.wr_mode);
      rd_num     = CNT_WIDTH'(bus.rd_mode);
      wr_mode_ok = (bus.wr_mode != 3'd0) && (bus.wr_mode <= 3'(WR_MODE_MAX));
      rd_mode_ok = (bus.rd_mode != 2'd0) && (bus.rd_mode <= 2'(RD_MODE_MAX));

      // Acceptance uses start-of-cycle room only; a same-cycle pop frees nothing.
      wr_accept  = bus.wr_en && wr_mode_ok && (wr_num <= avail);
      wr_drop    = bus.wr_en && wr_mode_ok && (wr_num > avail);
      rd_short   = bus.rd_en && rd_mode_ok && (rd_num > count_q);

      wr_cnt = wr_accept ? wr_num : '0;
      rd_cnt = '0;
      if (bus.rd_en && rd_mode_ok) begin
         rd_cnt = rd_short ? count_q : rd_num;
      end

      for (int i = 0; i < WR_MODE_MAX; i++) begin
         wr_slot[i] = ADDR_WIDTH'(ptr_add(32'(wr_ptr_q), i, FIFO_DEPTH));
      end
      wr_ptr_next = ADDR_WIDTH'(ptr_add(32'(wr_ptr_q), 32'(wr_cnt), FIFO_DEPTH));
      rd_ptr_next = ADDR_WIDTH'(ptr_add(32'(rd_ptr_q), 32'(rd_cnt), FIFO_DEPTH));
      rd_ptr_inc  = ADDR_WIDTH'(ptr_add(32'(rd_ptr_q), 1, FIFO_DEPTH));
   end

   // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
   always_ff @(posedge clk) begin
      if (arst) begin
         // NOTE: the storage array is reset on purpose; every slot must read as NO_SOURCE after reset.
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= EMPTY_ENTRY;
         end
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         for (int i = 0; i < WR_MODE_MAX; i++) begin
            if (CNT_WIDTH'(i) < wr_cnt) begin
               mem_q[wr_slot[i]] <= wr_data[i];
            end
         end
         wr_ptr_q    <= wr_ptr_next;
         rd_ptr_q    <= rd_ptr_next;
         count_q     <= count_q + wr_cnt - rd_cnt;
         overflow_q  <= wr_drop;
         underflow_q <= rd_short;
      end
   end

   // Status and show-ahead data depend on registered state only.
   assign bus.rd_data_1 = (count_q >= CNT_WIDTH'(1)) ? mem_q[rd_ptr_q]   : EMPTY_ENTRY;
   assign bus.rd_data_2 = (count_q >= CNT_WIDTH'(2)) ? mem_q[rd_ptr_inc] : EMPTY_ENTRY;
   assign bus.empty     = (count_q == '0);
   assign bus.full      = (count_q == DEPTH_CNT);
   assign bus.available = avail;
   assign bus.overflow  = overflow_q;
   assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_tx_sequence_recorder_fifo.sv
// Directed bench for tx_sequence_recorder_fifo: reset, wide push/pop,
// wrap-around, overflow, full push+pop, underflow and mid-operation reset.
module tb_tx_sequence_recorder_fifo;
   import tx_sequence_recorder_fifo_pkg::*;

   localparam int DW    = 3;
   localparam int DEPTH = 10;
   localparam int CW    = $clog2(DEPTH + 1);

   logic clk;
   logic arst;
   int   n_checks;
   int   n_fail;

   tx_sequence_recorder_fifo_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();

   tx_sequence_recorder_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
      .clk  (clk),
      .arst (arst),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_idle();
      bus.wr_en     = 1'b0;
      bus.wr_mode   = 3'd0;
      bus.wr_data_1 = NO_SOURCE;
      bus.wr_data_2 = NO_SOURCE;
      bus.wr_data_3 = NO_SOURCE;
      bus.wr_data_4 = NO_SOURCE;
      bus.rd_en     = 1'b0;
      bus.rd_mode   = 2'd0;
   endtask

   // Apply one cycle of stimulus, then return at the following falling edge.
   task automatic cycle(input logic wr, input logic [2:0] wm,
                        input logic [2:0] d1, input logic [2:0] d2,
                        input logic [2:0] d3, input logic [2:0] d4,
                        input logic rd, input logic [1:0] rm);
      bus.wr_en     = wr;
      bus.wr_mode   = wm;
      bus.wr_data_1 = d1;
      bus.wr_data_2 = d2;
      bus.wr_data_3 = d3;
      bus.wr_data_4 = d4;
      bus.rd_en     = rd;
      bus.rd_mode   = rm;
      @(posedge clk);
      @(negedge clk);
      set_idle();
   endtask

   task automatic idle_cycle();
      cycle(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 2'd0);
   endtask

   task automatic test_reset();
      arst = 1'b1;
      idle_cycle();
      idle_cycle();
      n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
      n_checks++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", bus.full); end
      n_checks++; if (bus.available !== CW'(DEPTH)) begin n_fail++; $display("FAIL reset_available: got %0d want %0d", bus.available, DEPTH); end
      n_checks++; if (bus.rd_data_1 !== NO_SOURCE || bus.rd_data_2 !== NO_SOURCE) begin n_fail++; $display("FAIL reset_rd_data: got %0d/%0d want 0/0", bus.rd_data_1, bus.rd_data_2); end
      n_checks++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got ovf=%b unf=%b want 0/0", bus.overflow, bus.underflow); end
      arst = 1'b0;
      idle_cycle();
      n_checks++; if (bus.empty !== 1'b1 || bus.available !== CW'(DEPTH)) begin n_fail++; $display("FAIL reset_idle: got empty=%b avail=%0d want 1/%0d", bus.empty, bus.available, DEPTH); end
   endtask

   task automatic test_push4();
      cycle(1'b1, 3'd4, A2P_1, A2P_2, MASTER, RX_ROUTER_ERR, 1'b0, 2'd0);
      n_checks++; if (bus.available !== CW'(6)) begin n_fail++; $display("FAIL push4_available: got %0d want 6", bus.available); end
      n_checks++; if (bus.empty !== 1'b0) begin n_fail++; $display("FAIL push4_empty: got %b want 0", bus.empty); end
      n_checks++; if (bus.rd_data_1 !== A2P_1 || bus.rd_data_2 !== A2P_2) begin n_fail++; $display("FAIL push4_head: got %0d/%0d want 1/2", bus.rd_data_1, bus.rd_data_2); end
      cycle(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1, 2'd2);
      n_checks++; if (bus.rd_data_1 !== MASTER || bus.rd_data_2 !== RX_ROUTER_ERR) begin n_fail++; $display("FAIL pop2_head: got %0d/%0d want 3/5", bus.rd_data_1, bus.rd_data_2); end
      n_checks++; if (bus.available !== CW'(8)) begin n_fail++; $display("FAIL pop2_available: got %0d want 8", bus.available); end
      cycle(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1, 2'd2);
      n_checks++; if (bus.empty !== 1'b1 || bus.rd_data_1 !== NO_SOURCE || bus.underflow !== 1'b0) begin n_fail++; $display("FAIL pop2_drain: got empty=%b rd1=%0d unf=%b want 1/0/0", bus.empty, bus.rd_data_1, bus.underflow); end
   endtask

   task automatic test_wrap();
      logic [2:0] exp1 [4];
      logic [2:0] exp2 [4];
      logic [2:0] wexp1 [4];
      logic [2:0] wexp2 [4];
      exp1  = '{A2P_1, MASTER, RX_ROUTER_ERR, A2P_2};
      exp2  = '{A2P_2, RX_ROUTER_CFG, A2P_1, MASTER};
      wexp1 = '{RX_ROUTER_CFG, RX_ROUTER_ERR, A2P_1, A2P_2};
      wexp2 = '{RX_ROUTER_ERR, A2P_1, A2P_2, NO_SOURCE};
      arst = 1'b1;
      idle_cycle();
      arst = 1'b0;
      cycle(1'b1, 3'd4, A2P_1, A2P_2, MASTER, RX_ROUTER_CFG, 1'b0, 2'd0);
      cycle(1'b1, 3'd4, RX_ROUTER_ERR, A2P_1, A2P_2, MASTER, 1'b0, 2'd0);
      n_checks++; if (bus.available !== CW'(2)) begin n_fail++; $display("FAIL wrap_fill8: got %0d want 2", bus.available); end
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (bus.rd_data_1 !== exp1[i] || bus.rd_data_2 !== exp2[i]) begin n_fail++; $display("FAIL wrap_drain_%0d: got %0d/%0d want %0d/%0d", i, bus.rd_data_1, bus.rd_data_2, exp1[i], exp2[i]); end
         cycle(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1, 2'd2);
      end
      n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty8: got %b want 1", bus.empty); end
      // Pointers now sit at slot 8, so this push lands in slots 8, 9, 0, 1.
      cycle(1'b1, 3'd4, RX_ROUTER_CFG, RX_ROUTER_ERR, A2P_1, A2P_2, 1'b0, 2'd0);
      n_checks++; if (bus.available !== CW'(6)) begin n_fail++; $display("FAIL wrap_push_avail: got %0d want 6", bus.available); end
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (bus.rd_data_1 !== wexp1[i] || bus.rd_data_2 !== wexp2[i]) begin n_fail++; $display("FAIL wrap_pop_%0d: got %0d/%0d want %0d/%0d", i, bus.rd_data_1, bus.rd_data_2, wexp1[i], wexp2[i]); end
         cycle(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1, 2'd1);
      end
      n_checks++; if (bus.empty !== 1'b1 || bus.available !== CW'(DEPTH)) begin n_fail++; $display("FAIL wrap_end: got empty=%b avail=%0d want 1/%0d", bus.empty, bus.available, DEPTH); end
   endtask

   task automatic test_noop();
      cycle(1'b1, 3'd0, A2P_1, A2P_1, A2P_1, A2P_1, 1'b1, 2'd0);
      n_checks++; if (bus.empty !== 1'b1 || bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin n_fail++; $display("FAIL noop_mode0: got empty=%b ovf=%b unf=%b want 1/0/0", bus.empty, bus.overflow, bus.underflow); end
      cycle(1'b1, 3'd5, A2P_1, A2P_1, A2P_1, A2P_1, 1'b0, 2'd0);
      n_checks++; if (bus.available !== CW'(DEPTH) || bus.overflow !== 1'b0) begin n_fail++; $display("FAIL noop_mode5: got avail=%0d ovf=%b want %0d/0", bus.available, bus.overflow, DEPTH); end
   endtask

   task automatic test_no_bypass();
      // Push into empty while popping: the pop sees count=0, the push lands.
      cycle(1'b1, 3'd1, MASTER, 3'd0, 3'd0, 3'd0, 1'b1, 2'd1);
      n_checks++; if (bus.underflow !== 1'b1) begin n_fail++; $display("FAIL bypass_underflow: got %b want 1", bus.underflow); end
      n_checks++; if (bus.rd_data_1 !== MASTER || bus.available !== CW'(9)) begin n_fail++; $display("FAIL bypass_data: got rd1=%0d avail=%0d want 3/9", bus.rd_data_1, bus.available); end
      cycle(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1, 2'd1);
      n_checks++; if (bus.empty !== 1'b1 || bus.underflow !== 1'b0) begin n_fail++; $display("FAIL bypass_drain: got empty=%b unf=%b want 1/0", bus.empty, bus.underflow); end
   endtask

   task automatic test_overflow();
      cycle(1'b1, 3'd4, A2P_1, A2P_2, MASTER, RX_ROUTER_CFG, 1'b0, 2'd0);
      cycle(1'b1, 3'd4, RX_ROUTER_ERR, RX_ROUTER_CFG, MASTER, A2P_2, 1'b0, 2'd0);
      cycle(1'b1, 3'd3, RX_ROUTER_ERR, RX_ROUTER_ERR, RX_ROUTER_ERR, 3'd0, 1'b0, 2'd0);
      n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse: got %b want 1", bus.overflow); end
      n_checks++; if (bus.available !== CW'(2) || bus.full !== 1'b0) begin n_fail++; $display("FAIL ovf_dropped: got avail=%0d full=%b want 2/0", bus.available, bus.full); end
      idle_cycle();
      n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_one_cycle: got %b want 0", bus.overflow); end
      cycle(1'b1, 3'd2, A2P_1, MASTER, 3'd0, 3'd0, 1'b0, 2'd0);
      n_checks++; if (bus.full !== 1'b1 || bus.available !== CW'(0) || bus.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_fill: got full=%b avail=%0d ovf=%b want 1/0/0", bus.full, bus.available, bus.overflow); end
      n_checks++; if (bus.rd_data_1 !== A2P_1 || bus.rd_data_2 !== A2P_2) begin n_fail++; $display("FAIL ovf_head: got %0d/%0d want 1/2", bus.rd_data_1, bus.rd_data_2); end
   endtask

   task automatic test_full_push_pop();
      cycle(1'b1, 3'd1, RX_ROUTER_ERR, 3'd0, 3'd0, 3'd0, 1'b1, 2'd2);
      n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL full_pp_ovf: got %b want 1", bus.overflow); end
      n_checks++; if (bus.available !== CW'(2) || bus.full !== 1'b0) begin n_fail++; $display("FAIL full_pp_count: got avail=%0d full=%b want 2/0", bus.available, bus.full); end
      n_checks++; if (bus.rd_data_1 !== MASTER || bus.rd_data_2 !== RX_ROUTER_CFG) begin n_fail++; $display("FAIL full_pp_head: got %0d/%0d want 3/4", bus.rd_data_1, bus.rd_data_2); end
   endtask

   task automatic test_underflow_reset();
      // Remaining: MASTER CFG ERR CFG MASTER A2P_2 A2P_1 MASTER -> drain to one entry.
      cycle(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1, 2'd2);
      cycle(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1, 2'd2);
      cycle(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1, 2'd2);
      cycle(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1, 2'd1);
      n_checks++; if (bus.rd_data_1 !== MASTER || bus.rd_data_2 !== NO_SOURCE || bus.available !== CW'(9)) begin n_fail++; $display("FAIL unf_one_left: got %0d/%0d avail=%0d want 3/0/9", bus.rd_data_1, bus.rd_data_2, bus.available); end
      cycle(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1, 2'd2);
      n_checks++; if (bus.underflow !== 1'b1 || bus.empty !== 1'b1) begin n_fail++; $display("FAIL unf_pulse: got unf=%b empty=%b want 1/1", bus.underflow, bus.empty); end
      idle_cycle();
      n_checks++; if (bus.underflow !== 1'b0) begin n_fail++; $display("FAIL unf_one_cycle: got %b want 0", bus.underflow); end
      cycle(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1, 2'd1);
      n_checks++; if (bus.underflow !== 1'b1) begin n_fail++; $display("FAIL unf_empty_read: got %b want 1", bus.underflow); end
      // Reset wins over a concurrent push and pop.
      arst = 1'b1;
      cycle(1'b1, 3'd4, A2P_1, A2P_2, MASTER, RX_ROUTER_CFG, 1'b1, 2'd1);
      n_checks++; if (bus.empty !== 1'b1 || bus.available !== CW'(DEPTH) || bus.underflow !== 1'b0 || bus.overflow !== 1'b0) begin n_fail++; $display("FAIL rst_mid: got empty=%b avail=%0d ovf=%b unf=%b want 1/%0d/0/0", bus.empty, bus.available, bus.overflow, bus.underflow, DEPTH); end
      arst = 1'b0;
      idle_cycle();
      n_checks++; if (bus.empty !== 1'b1 || bus.rd_data_1 !== NO_SOURCE || bus.rd_data_2 !== NO_SOURCE) begin n_fail++; $display("FAIL rst_mid_nothing_stored: got empty=%b rd=%0d/%0d want 1/0/0", bus.empty, bus.rd_data_1, bus.rd_data_2); end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      arst     = 1'b1;
      set_idle();
      @(negedge clk);
      test_reset();
      test_push4();
      test_wrap();
      test_noop();
      test_no_bypass();
      test_overflow();
      test_full_push_pop();
      test_underflow_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
